// File: rtl/stream_mux_pkg.sv
// Shared mode constants and width helper for the stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin search: first asserted req at or above ptr, wrapping N-1 -> 0.
// Purely combinational; one-hot gnt plus its binary index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  logic [SW:0]   w_sum;
  logic [SW-1:0] w_k;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate (ptr + i) mod N; ptr < N keeps the sum below 2N.
      w_sum = {1'b0, ptr} + (SW+1)'(i);
      if (w_sum >= (SW+1)'(N)) w_sum = w_sum - (SW+1)'(N);
      w_k = w_sum[SW-1:0];
      if (!w_found && req[w_k]) begin
        w_found  = 1'b1;
        gnt[w_k] = 1'b1;
        gnt_idx  = w_k;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 valid/ready stream mux, fixed-select or round-robin, one-cycle registered output.
// IN_READY is combinational from the grant; the output slot refills in the same cycle it drains.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic           CLK,
  input  logic           RSTbar,
  input  logic           Gbar,
  input  logic           MODE,
  input  logic [SW-1:0]  SEL,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
  output logic [W-1:0]   Y,
  output logic           Y_VALID,
  input  logic           Y_READY,
  output logic [SW-1:0]  Y_CH
);

  logic [W-1:0]  r_y;
  logic [SW-1:0] r_y_ch;
  logic          r_y_vld;
  logic [SW-1:0] r_ptr;

  logic          w_free;
  logic          w_en;
  logic          w_xfer;
  logic [N-1:0]  w_rr_gnt;
  logic [N-1:0]  w_fix_gnt;
  logic [N-1:0]  w_gnt;
  logic [SW-1:0] w_rr_idx;
  logic [SW-1:0] w_gnt_idx;
  logic [SW-1:0] w_ptr_nxt;
  logic [W-1:0]  w_dat;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_rr (
    .req     (IN_VALID),
    .ptr     (r_ptr),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx)
  );

  assign w_free = !r_y_vld || Y_READY;
  assign w_en   = w_free && !Gbar && RSTbar;

  // A SEL value at or beyond N matches no channel, so nothing is granted.
  always_comb begin
    w_fix_gnt = '0;
    for (int k = 0; k < N; k++) begin
      if (SEL == SW'(k)) w_fix_gnt[k] = IN_VALID[k];
    end
  end

  assign w_gnt     = w_en ? ((MODE == MODE_RR) ? w_rr_gnt : w_fix_gnt) : '0;
  assign w_gnt_idx = (MODE == MODE_RR) ? w_rr_idx : SEL;
  assign w_xfer    = |w_gnt;
  assign IN_READY  = w_gnt;

  always_comb begin
    w_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gnt[k]) w_dat = IN_DATA[k*W +: W];
    end
  end

  assign w_ptr_nxt = (w_rr_idx == SW'(N-1)) ? '0 : w_rr_idx + 1'b1;

  always_ff @(posedge CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      r_y     <= '0;
      r_y_ch  <= '0;
      r_y_vld <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_y     <= w_dat;
      r_y_ch  <= w_gnt_idx;
      r_y_vld <= 1'b1;
      if (MODE == MODE_RR) r_ptr <= w_ptr_nxt;
    end else if (Y_READY) begin
      r_y_vld <= 1'b0;
    end
  end

  assign Y       = r_y;
  assign Y_CH    = r_y_ch;
  assign Y_VALID = r_y_vld;

endmodule

// File: tb/tb_stream_mux.sv
// Directed plus randomized checks of stream_mux against a queue-free behavioural model.
module tb_stream_mux;

  localparam int NCH = 4;

  logic        clk;
  logic        rst_n;
  logic        gbar, mode, y_rdy, y_vld;
  logic [1:0]  sel, y_ch;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  y;

  logic        gbar3, mode3, y_rdy3, y_vld3;
  logic [1:0]  sel3, y_ch3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  y3;

  stream_mux #(.W(8), .N(4)) dut (
    .CLK(clk), .RSTbar(rst_n), .Gbar(gbar), .MODE(mode), .SEL(sel),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .Y(y), .Y_VALID(y_vld), .Y_READY(y_rdy), .Y_CH(y_ch)
  );

  stream_mux #(.W(8), .N(3)) dut3 (
    .CLK(clk), .RSTbar(rst_n), .Gbar(gbar3), .MODE(mode3), .SEL(sel3),
    .IN_DATA(in_data3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
    .Y(y3), .Y_VALID(y_vld3), .Y_READY(y_rdy3), .Y_CH(y_ch3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic       m_vld;
  logic [7:0] m_y;
  int         m_ch;
  int         m_ptr;
  logic [7:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    g = '0;
    if (rst_n && !gbar && (!m_vld || y_rdy)) begin
      if (mode == 1'b0) begin
        if (int'(sel) < NCH && in_valid[sel]) g[sel] = 1'b1;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          int c;
          c = (m_ptr + i) % NCH;
          if (in_valid[c]) begin
            g[c] = 1'b1;
            break;
          end
        end
      end
    end
    return g;
  endfunction

  task automatic model_update(input logic [3:0] g);
    if (g != 4'b0) begin
      for (int c = 0; c < NCH; c++) begin
        if (g[c]) begin
          m_y  = in_data[c*8 +: 8];
          m_ch = c;
          if (mode) m_ptr = (c + 1) % NCH;
        end
      end
      m_vld = 1'b1;
    end else if (y_rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic step(input string tag);
    logic [3:0] g;
    #1;
    g = model_grant();
    check({tag, "/rdy"}, 32'(in_ready), 32'(g));
    check({tag, "/vld"}, 32'(y_vld), 32'(m_vld));
    check({tag, "/y"},   32'(y), 32'(m_y));
    check({tag, "/ch"},  32'(y_ch), 32'(m_ch));
    check({tag, "/ptr"}, 32'(dut.r_ptr), 32'(m_ptr));
    @(posedge clk);
    model_update(g);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; gbar = 1'b0; mode = 1'b0; sel = 2'd0; y_rdy = 1'b1;
    in_data = 32'h44332211; in_valid = 4'hF;
    gbar3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; y_rdy3 = 1'b1;
    in_data3 = 24'h332211; in_valid3 = 3'b000;
    m_vld = 1'b0; m_y = '0; m_ch = 0; m_ptr = 0;

    @(negedge clk);
    check("rst/y",   32'(y), 0);
    check("rst/vld", 32'(y_vld), 0);
    check("rst/ch",  32'(y_ch), 0);
    check("rst/rdy", 32'(in_ready), 0);
    check("rst/ptr", 32'(dut.r_ptr), 0);
    rst_n = 1'b1;

    // Fixed select, first edge after release.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A50000; y_rdy = 1'b1;
    #1 check("fix/rdy", 32'(in_ready), 32'b0100);
    step("fix");
    check("fix/y",   32'(y), 32'hA5);
    check("fix/ch",  32'(y_ch), 2);
    check("fix/vld", 32'(y_vld), 1);

    // Round-robin over all-valid channels, one word per cycle.
    mode = 1'b1; in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom | 32'h01010101;
      step("rr");
      check("rr/order", 32'(y_ch), i % 4);
      check("rr/rate",  32'(y_vld), 1);
    end

    // Backpressure holds the word and blocks grants, then same-cycle refill.
    y_rdy = 1'b0; held = y;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom | 32'h01010101;
      #1 check("hold/rdy", 32'(in_ready), 0);
      step("hold");
      check("hold/y", 32'(y), 32'(held));
    end
    y_rdy = 1'b1;
    #1 check("refill/rdy", 32'(in_ready), 32'b0001);
    step("refill");
    check("refill/ch", 32'(y_ch), 0);

    // Gbar blocks grants but not draining.
    gbar = 1'b1;
    #1 check("gbar/rdy", 32'(in_ready), 0);
    step("gbar");
    check("gbar/drain", 32'(y_vld), 0);
    step("gbar2");
    gbar = 1'b0;
    #1 check("gbar/resume", 32'(in_ready), 32'b0010);
    step("resume");
    check("resume/vld", 32'(y_vld), 1);
    check("resume/ch",  32'(y_ch), 1);

    // Asynchronous reset between edges while a word is held.
    y_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst/vld", 32'(y_vld), 0);
    check("arst/y",   32'(y), 0);
    check("arst/ptr", 32'(dut.r_ptr), 0);
    check("arst/rdy", 32'(in_ready), 0);
    m_vld = 1'b0; m_y = '0; m_ch = 0; m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      gbar     = ($urandom_range(0, 7) == 0);
      mode     = 1'($urandom_range(0, 1));
      sel      = 2'($urandom);
      in_valid = 4'($urandom);
      in_data  = $urandom;
      y_rdy    = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Three-channel instance: out-of-range select and wrap-around search.
    gbar3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; y_rdy3 = 1'b1;
    #1 check("n3/sel3", 32'(in_ready3), 0);
    @(negedge clk);
    check("n3/novld", 32'(y_vld3), 0);
    mode3 = 1'b1; in_valid3 = 3'b010;
    #1 check("n3/rdy1", 32'(in_ready3), 32'b010);
    @(negedge clk);
    check("n3/ptr2", 32'(dut3.r_ptr), 2);
    check("n3/ch1",  32'(y_ch3), 1);
    in_valid3 = 3'b001;
    #1 check("n3/wrap", 32'(in_ready3), 32'b001);
    @(negedge clk);
    check("n3/ch0",  32'(y_ch3), 0);
    check("n3/y",    32'(y3), 32'h11);
    check("n3/ptr1", 32'(dut3.r_ptr), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
